uart_receiver_controller: RTL and testbench
===========================================

// Module: uart_receiver_controller
// PURPOSE
//  Serial-to-parallel UART receive end for the 8N1 frames made by the board transmitter controller.
//  Oversamples ser_in at 16x the selected baud rate, validates the start bit,
//  shifts in 8 data bits LSB first and checks the stop bit.
//  Presents the received byte to board logic through a valid/ack handshake.
// PARAMETERS
//  CLK_FREQ_HZ  100_000_000  input clock frequency
//  OVERSAMPLE   16           ticks per bit; fixed, not tunable
// PORTS
//  clk_in      in   1  system clock, single clock domain
//  reset       in   1  asynchronous, active-low reset
//  S           in   2  baud select: 00=9600, 01=19200, 10=57600, 11=115200
//  ser_in      in   1  asynchronous serial line, idles high
//  data_ack    in   1  board has consumed data_out; clears data_valid
//  data_out    out  8  last good received byte
//  data_valid  out  1  level; high from frame accept until data_ack
//  frame_err   out  1  sticky; stop bit sampled 0; cleared by next good frame
//  overrun     out  1  sticky; good frame completed while data_valid=1; cleared by data_ack
//  busy        out  1  high in any state other than IDLE
// BEHAVIOUR
//  Reset: all outputs 0.
//   - State IDLE, ser_in synchroniser flops preset to 1, all counters 0.
//   - Reset asserted mid-frame aborts the frame silently. No partial byte is delivered.
//  Sync: ser_in goes through a 2-flop synchroniser. All decisions use the synchronised value rx_s.
//  Tick: divisor = CLK_FREQ_HZ/(baud*16), rounded (100 MHz: 651/326/109/54).
//   - A one-clk pulse, tick, fires each time the divisor count wraps.
//   - S is latched only in IDLE. A change of S mid-frame takes effect at the next frame.
//  FSM (sample counter sc 0..15 advances on tick; bit counter bc 0..7):
//   IDLE:  rx_s==0 -> START, sc=0, tick generator restarted.
//   START: at tick with sc==7 (start-bit midpoint):
//          - rx_s==0 -> DATA, sc=0, bc=0
//          - else -> IDLE (glitch rejected, no flag set)
//   DATA:  at tick with sc==15 (data-bit midpoint): shift_reg={rx_s, shift_reg[7:1]} (LSB first).
//          - bc==7 -> STOP, else bc++
//   STOP:  at tick with sc==15:
//          - rx_s==1 -> data_out<=shift_reg, data_valid<=1, frame_err<=0, -> IDLE
//          - rx_s==0 -> frame_err<=1, data_out unchanged, -> BREAK
//   BREAK: wait for rx_s==1 -> IDLE. A held-low line (break) never retriggers START.
//  Latency: data_valid rises 1 clk after the stop-bit midpoint sample (about 9.5 bit times after the start edge).
//  Handshake:
//   - data_ack with data_valid=1 clears data_valid and overrun next clk.
//   - data_ack with data_valid=0 is ignored.
//  Overrun: a good frame completes while data_valid=1 and no data_ack arrives in the same clk.
//   - data_out is overwritten and overrun<=1.
//  Same-clk data_ack + frame accept: new byte loaded, data_valid stays 1, overrun not set.
//  Back-to-back frames: a falling edge seen in IDLE right after STOP is accepted. No idle bit time required.
//  Illegal state encoding -> IDLE.
// STRUCTURE
//  Package uart_pkg:
//   - rx_state_t enum {IDLE, START, DATA, STOP, BREAK}
//   - BAUD_9600..BAUD_115200 constants
//   - function baud_div(clk_hz, sel) returning the divisor
//  Sub-module uart_rx_tick_gen: S latch plus divisor counter. Inputs: clk_in, reset, S, restart. Output: tick.
//  Top: synchroniser, FSM, sc/bc counters, shift register, output/flag registers.
// TESTING
//  1. S=11, send 0xA5 as a clean 8N1 frame -> data_out=0xA5, data_valid=1, frame_err=0. data_ack clears valid.
//  2. S=00, ser_in low pulse of 4 ticks (< half bit) -> back to IDLE, data_valid stays 0, no flags.
//  3. S=10, frame 0x3C with stop bit forced 0, line held low 2 bit times:
//     -> frame_err=1, data_valid=0, data_out unchanged.
//     Then a good 0x81 frame -> data_out=0x81, frame_err=0.
//  4. S=11, frames 0x11 then 0x22 with no data_ack -> data_out=0x22, overrun=1. data_ack clears both flags.
//  5. Reset pulsed low during bit 4 of 0xFF -> outputs 0, busy=0. Next frame 0x5A received correctly.
//  6. S changed 01->11 mid-frame of 0x69 -> 0x69 received at 19200. Following 0x96 at 115200 received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Divisors are derived from the clock frequency and the 2-bit baud select.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    localparam logic [1:0] BAUD_9600   = 2'b00;
    localparam logic [1:0] BAUD_19200  = 2'b01;
    localparam logic [1:0] BAUD_57600  = 2'b10;
    localparam logic [1:0] BAUD_115200 = 2'b11;

    localparam int unsigned OVERSAMPLE = 16;
    localparam logic [3:0]  SC_MID     = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]  SC_LAST    = 4'(OVERSAMPLE - 1);

    // Rounded clk_hz / (baud * 16)
    function automatic int unsigned baud_div(input int unsigned clk_hz, input logic [1:0] sel);
        int unsigned baud;
        case (sel)
            BAUD_9600:   baud = 9600;
            BAUD_19200:  baud = 19200;
            BAUD_57600:  baud = 57600;
            BAUD_115200: baud = 115200;
        endcase
        return (clk_hz + baud * (OVERSAMPLE / 2)) / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// 16x oversample tick generator; the baud select is captured on restart,
// which the receiver only issues from IDLE, so mid-frame changes wait a frame.
module uart_rx_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic [1:0] S,
    input  logic       restart,
    output logic       tick
);

    localparam logic [15:0] DIV_9600   = 16'(baud_div(CLK_FREQ_HZ, BAUD_9600));
    localparam logic [15:0] DIV_19200  = 16'(baud_div(CLK_FREQ_HZ, BAUD_19200));
    localparam logic [15:0] DIV_57600  = 16'(baud_div(CLK_FREQ_HZ, BAUD_57600));
    localparam logic [15:0] DIV_115200 = 16'(baud_div(CLK_FREQ_HZ, BAUD_115200));

    logic [1:0]  sel;
    logic [15:0] cnt;
    logic [15:0] div;
    logic        wrap;

    always_comb begin
        div = DIV_115200;
        case (sel)
            BAUD_9600:   div = DIV_9600;
            BAUD_19200:  div = DIV_19200;
            BAUD_57600:  div = DIV_57600;
            BAUD_115200: div = DIV_115200;
        endcase
    end

    assign wrap = (cnt == div - 16'd1);
    assign tick = wrap && !restart;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            sel <= BAUD_9600;
            cnt <= '0;
        end else if (restart) begin
            sel <= S;
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/uart_receiver_controller.sv
// 8N1 UART receiver: synchroniser, frame FSM, shift register and the
// valid/ack handshake with sticky frame-error and overrun flags.
module uart_receiver_controller
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic [1:0] S,
    input  logic       ser_in,
    input  logic       data_ack,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    rx_state_t  state, state_nx;
    logic       rx_meta, rx_s;
    logic [3:0] sc;
    logic [2:0] bc;
    logic [7:0] shift_reg;
    logic       tick, restart, sc_clr, bc_inc, shift_en, accept, ferr_set;

    uart_rx_tick_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
        .clk_in  (clk_in),
        .reset   (reset),
        .S       (S),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        restart  = 1'b0;
        sc_clr   = 1'b0;
        bc_inc   = 1'b0;
        shift_en = 1'b0;
        accept   = 1'b0;
        ferr_set = 1'b0;
        case (state)
            IDLE: if (!rx_s) begin
                state_nx = START;
                restart  = 1'b1;
                sc_clr   = 1'b1;
            end
            START: if (tick && sc == SC_MID) begin
                if (!rx_s) begin
                    state_nx = DATA;
                    sc_clr   = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            DATA: if (tick && sc == SC_LAST) begin
                shift_en = 1'b1;
                if (bc == 3'd7) state_nx = STOP;
                else            bc_inc   = 1'b1;
            end
            STOP: if (tick && sc == SC_LAST) begin
                if (rx_s) begin
                    accept   = 1'b1;
                    state_nx = IDLE;
                end else begin
                    ferr_set = 1'b1;
                    state_nx = BREAK;
                end
            end
            // Held-low line must return high before a new start can be seen
            BREAK: if (rx_s) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            sc         <= '0;
            bc         <= '0;
            shift_reg  <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_meta <= ser_in;
            rx_s    <= rx_meta;

            if (sc_clr)                      sc <= '0;
            else if (tick && state != IDLE)  sc <= sc + 4'd1;

            if (sc_clr)      bc <= '0;
            else if (bc_inc) bc <= bc + 3'd1;

            if (shift_en) shift_reg <= {rx_s, shift_reg[7:1]};

            if (accept) begin
                data_out   <= shift_reg;
                data_valid <= 1'b1;
                frame_err  <= 1'b0;
                // A same-cycle ack consumes the old byte, so no overrun
                if (data_valid && !data_ack)     overrun <= 1'b1;
                else if (data_valid && data_ack) overrun <= 1'b0;
            end else begin
                if (data_ack && data_valid) begin
                    data_valid <= 1'b0;
                    overrun    <= 1'b0;
                end
                if (ferr_set) frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver_controller.sv
// Scenario bench for the UART receiver: drives 8N1 frames bit by bit and
// compares outputs against a byte-level handshake model.
module tb_uart_receiver_controller;
    import uart_pkg::*;

    localparam int unsigned CLK_HZ = 10_000_000;

    logic       clk_in   = 1'b0;
    logic       reset    = 1'b0;
    logic [1:0] S        = 2'b00;
    logic       ser_in   = 1'b1;
    logic       data_ack = 1'b0;
    logic [7:0] data_out;
    logic       data_valid, frame_err, overrun, busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_data  = 8'h00;
    logic       exp_valid = 1'b0;
    logic       exp_ferr  = 1'b0;
    logic       exp_ovr   = 1'b0;

    wire [10:0] obs = {data_out, data_valid, frame_err, overrun};

    uart_receiver_controller #(.CLK_FREQ_HZ(CLK_HZ)) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .S          (S),
        .ser_in     (ser_in),
        .data_ack   (data_ack),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Clocks per bit from the nominal baud rate, rounded to nearest divisor
    function automatic int bit_clks(input logic [1:0] sel);
        real baud;
        case (sel)
            2'b00:   baud = 9600.0;
            2'b01:   baud = 19200.0;
            2'b10:   baud = 57600.0;
            default: baud = 115200.0;
        endcase
        return 16 * $rtoi(real'(CLK_HZ) / (baud * 16.0) + 0.5);
    endfunction

    function automatic void model_accept(input logic [7:0] d);
        if (exp_valid) exp_ovr = 1'b1;
        exp_data  = d;
        exp_valid = 1'b1;
        exp_ferr  = 1'b0;
    endfunction

    function automatic void model_ack();
        if (exp_valid) begin
            exp_valid = 1'b0;
            exp_ovr   = 1'b0;
        end
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic drive_bit(input logic b, input int n);
        ser_in = b;
        wait_clks(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int n);
        drive_bit(1'b0, n);
        for (int i = 0; i < 8; i++) drive_bit(d[i], n);
        drive_bit(stop, n);
    endtask

    task automatic pulse_ack();
        data_ack = 1'b1;
        wait_clks(1);
        data_ack = 1'b0;
        model_ack();
    endtask

    task automatic test_reset();
        reset  = 1'b0;
        ser_in = 1'b1;
        wait_clks(3);
        checks++;
        if (obs !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=%h", obs, 11'd0);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
        reset = 1'b1;
        wait_clks(3);
    endtask

    task automatic test_divisors();
        int exp_div[4] = '{651, 326, 109, 54};
        for (int i = 0; i < 4; i++) begin
            logic [1:0] sel = 2'(i);
            int unsigned got = baud_div(100_000_000, sel);
            checks++;
            if (got !== exp_div[i]) begin
                failures++;
                $display("FAIL divisor_sel%0d got=%0d exp=%0d", i, got, exp_div[i]);
            end
        end
    endtask

    task automatic test_clean();
        int n;
        logic [7:0] d = 8'hA5;
        S = 2'b11;
        n = bit_clks(S);
        drive_bit(1'b0, n);
        for (int i = 0; i < 8; i++) drive_bit(d[i], n);
        checks++;
        if ({busy, data_valid} !== 2'b10) begin
            failures++;
            $display("FAIL clean_before_stop got busy,valid=%b exp=10", {busy, data_valid});
        end
        drive_bit(1'b1, n);
        model_accept(d);
        checks++;
        if (obs !== {exp_data, exp_valid, exp_ferr, exp_ovr}) begin
            failures++;
            $display("FAIL clean_frame got=%h exp=%h", obs, {exp_data, exp_valid, exp_ferr, exp_ovr});
        end
        pulse_ack();
        wait_clks(1);
        checks++;
        if (obs !== {exp_data, exp_valid, exp_ferr, exp_ovr}) begin
            failures++;
            $display("FAIL clean_ack got=%h exp=%h", obs, {exp_data, exp_valid, exp_ferr, exp_ovr});
        end
    endtask

    task automatic test_glitch();
        int tk;
        S  = 2'b00;
        tk = bit_clks(S) / 16;
        drive_bit(1'b0, 4 * tk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL glitch_busy got=%b exp=1", busy);
        end
        drive_bit(1'b1, 16 * tk);
        checks++;
        if ({obs, busy} !== {exp_data, exp_valid, exp_ferr, exp_ovr, 1'b0}) begin
            failures++;
            $display("FAIL glitch_reject got=%h exp=%h", {obs, busy}, {exp_data, exp_valid, exp_ferr, exp_ovr, 1'b0});
        end
    endtask

    task automatic test_framing();
        int n;
        S = 2'b10;
        n = bit_clks(S);
        send_frame(8'h3C, 1'b0, n);
        drive_bit(1'b0, n);
        exp_ferr = 1'b1;
        checks++;
        if ({obs, busy} !== {exp_data, exp_valid, exp_ferr, exp_ovr, 1'b1}) begin
            failures++;
            $display("FAIL framing_err got=%h exp=%h", {obs, busy}, {exp_data, exp_valid, exp_ferr, exp_ovr, 1'b1});
        end
        drive_bit(1'b1, n);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL framing_break_exit got=%b exp=0", busy);
        end
        send_frame(8'h81, 1'b1, n);
        model_accept(8'h81);
        checks++;
        if (obs !== {exp_data, exp_valid, exp_ferr, exp_ovr}) begin
            failures++;
            $display("FAIL framing_recover got=%h exp=%h", obs, {exp_data, exp_valid, exp_ferr, exp_ovr});
        end
        pulse_ack();
    endtask

    task automatic test_back_to_back();
        int n;
        S = 2'b11;
        n = bit_clks(S);
        send_frame(8'h11, 1'b1, n);
        model_accept(8'h11);
        checks++;
        if (obs !== {exp_data, exp_valid, exp_ferr, exp_ovr}) begin
            failures++;
            $display("FAIL b2b_first got=%h exp=%h", obs, {exp_data, exp_valid, exp_ferr, exp_ovr});
        end
        send_frame(8'h22, 1'b1, n);
        model_accept(8'h22);
        checks++;
        if (obs !== {exp_data, exp_valid, exp_ferr, exp_ovr}) begin
            failures++;
            $display("FAIL b2b_overrun got=%h exp=%h", obs, {exp_data, exp_valid, exp_ferr, exp_ovr});
        end
        pulse_ack();
        checks++;
        if (obs !== {exp_data, exp_valid, exp_ferr, exp_ovr}) begin
            failures++;
            $display("FAIL b2b_ack_clear got=%h exp=%h", obs, {exp_data, exp_valid, exp_ferr, exp_ovr});
        end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        S = 2'b11;
        n = bit_clks(S);
        drive_bit(1'b0, n);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, n);
        wait_clks(n / 2);
        reset = 1'b0;
        wait_clks(2);
        exp_data = 8'h00; exp_valid = 1'b0; exp_ferr = 1'b0; exp_ovr = 1'b0;
        checks++;
        if ({obs, busy} !== 12'd0) begin
            failures++;
            $display("FAIL reset_mid_outputs got=%h exp=%h", {obs, busy}, 12'd0);
        end
        reset = 1'b1;
        wait_clks(2 * n);
        checks++;
        if ({obs, busy} !== 12'd0) begin
            failures++;
            $display("FAIL reset_mid_no_partial got=%h exp=%h", {obs, busy}, 12'd0);
        end
        send_frame(8'h5A, 1'b1, n);
        model_accept(8'h5A);
        checks++;
        if (obs !== {exp_data, exp_valid, exp_ferr, exp_ovr}) begin
            failures++;
            $display("FAIL reset_mid_next got=%h exp=%h", obs, {exp_data, exp_valid, exp_ferr, exp_ovr});
        end
        pulse_ack();
    endtask

    task automatic test_baud_change();
        int n;
        logic [7:0] d = 8'h69;
        S = 2'b01;
        n = bit_clks(2'b01);
        drive_bit(1'b0, n);
        for (int i = 0; i < 4; i++) drive_bit(d[i], n);
        S = 2'b11;
        for (int i = 4; i < 8; i++) drive_bit(d[i], n);
        drive_bit(1'b1, n);
        model_accept(d);
        checks++;
        if (obs !== {exp_data, exp_valid, exp_ferr, exp_ovr}) begin
            failures++;
            $display("FAIL baud_change_old got=%h exp=%h", obs, {exp_data, exp_valid, exp_ferr, exp_ovr});
        end
        pulse_ack();
        send_frame(8'h96, 1'b1, bit_clks(2'b11));
        model_accept(8'h96);
        checks++;
        if (obs !== {exp_data, exp_valid, exp_ferr, exp_ovr}) begin
            failures++;
            $display("FAIL baud_change_new got=%h exp=%h", obs, {exp_data, exp_valid, exp_ferr, exp_ovr});
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 12; k++) begin
            logic [1:0] sel  = 2'($urandom_range(2, 3));
            logic [7:0] d    = 8'($urandom);
            logic       good = ($urandom_range(0, 3) != 0);
            int         n    = bit_clks(sel);
            S = sel;
            if ($urandom_range(0, 1) == 1) pulse_ack();
            wait_clks($urandom_range(0, 2) * (n / 2));
            send_frame(d, good, n);
            if (good) begin
                model_accept(d);
            end else begin
                exp_ferr = 1'b1;
                drive_bit(1'b1, n);
            end
            checks++;
            if (obs !== {exp_data, exp_valid, exp_ferr, exp_ovr}) begin
                failures++;
                $display("FAIL random_%0d d=%h good=%b got=%h exp=%h", k, d, good, obs,
                         {exp_data, exp_valid, exp_ferr, exp_ovr});
            end
        end
    endtask

    initial begin
        test_reset();
        test_divisors();
        test_clean();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_reset_mid_frame();
        test_baud_change();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
